alu_serial_rx: RTL
==================

// Module: alu_serial_rx
// PURPOSE
//   Serial front end of the ALU DUT. Deserialises 10-bit frames from din while enable_n is low:
//   frame = {ctl, payload[7:0], parity}, MSB first. Data frames (ctl=0) push onto an operand stack.
//   A control frame (ctl=1) closes the command and presents {cmd, operands, error flags} to the
//   ALU core through a valid/ready handshake. Sits directly upstream of the ALU execute stage.
// PARAMETERS
//   DEPTH   8   operand stack entries (legal 2..15)
//   IDX_W   4   width of n_data / rd_idx; must hold DEPTH
// PORTS
//   clk       in   1      single clock, all logic on posedge
//   rst_n     in   1      asynchronous, active-low reset
//   enable_n  in   1      low = din carries a frame bit this cycle
//   din       in   1      serial data, MSB first
//   cmd_valid out  1      command frame pending
//   cmd_ready in   1      core accepts pending command
//   cmd       out  8      command payload
//   err       out  8      status_t-coded flags (OR of bits below)
//   n_data    out  IDX_W  number of operands stored
//   rd_idx    in   IDX_W  operand read index, 0 = oldest
//   rd_data   out  8      stack[rd_idx], combinational; 0 if rd_idx >= n_data
// BEHAVIOUR
//   - Reset (async assert, sync release): bit counter, shift reg, stack, n_data, cmd, err and
//     cmd_valid all 0.
//   - Sampling: din is shifted in on posedge when enable_n==0; the counter runs 0..9. The word
//     completes on the 10th sampled bit. enable_n high mid-word = abort: partial word discarded,
//     counter to 0, no flag.
//   - Parity check: the frame is good iff word[0] == ^word[9:1] (even parity over ctl+payload).
//   - Data frame, good parity, not full: push payload; n_data++.
//   - Data frame, good parity, full: drop it; set err[1] (S_DATA_STACK_OVERFLOW).
//   - Data frame, bad parity: not pushed; set err[5] (S_DATA_PARITY_ERROR).
//   - Control frame:
//     - cmd <= payload.
//     - Bad parity sets err[6] (S_COMMAND_PARITY_ERROR).
//     - n_data < 2 sets err[0] (S_MISSING_DATA).
//     - cmd_valid rises on the cycle after the 10th bit sample. Latency is 1 clk.
//   - Handshake: consumed on the posedge where cmd_valid && cmd_ready. Next cycle: cmd_valid=0,
//     n_data=0, err=0, cmd held. cmd/err/n_data/stack are stable while cmd_valid=1.
//   - While cmd_valid=1, completed frames are discarded. This includes a frame completing on the
//     handshake cycle itself. Bits still shift, so framing stays aligned.
//   - cmd_ready while cmd_valid=0 is ignored.
//   - Error flags are sticky from the first frame after a handshake or reset until the next
//     handshake.
//   - Command decode and S_INVALID_COMMAND belong to the core, not this block.
// STRUCTURE
//   - alu_pkg (shared with the core and the bench):
//     - command_t, status_t (S_* encodings)
//     - WORD_W=10
//     - function calc_parity(bit [8:0])
//   - Sub-module alu_rx_shifter: bit counter, shift reg, abort, parity check.
//     Outputs word_stb (1 clk), word[9:0], par_ok.
//   - Top holds the stack register file, n_data, err accumulation and the handshake register.
// TESTING
//   1. Data 0x05,0x03,0xFF then cmd 0x10, all good parity
//      -> cmd_valid 1 clk after the 40th bit; cmd=0x10, n_data=3, err=0x00;
//         rd_idx 0/1/2 -> 0x05/0x03/0xFF.
//   2. One data word 0xAA then cmd 0x01 -> err=0x01, n_data=1.
//   3. Nine data words 0x01..0x09 then cmd 0x01 (DEPTH=8)
//      -> err=0x02, n_data=8, rd_idx 7 -> 0x08.
//   4. Data 0x11 with parity bit flipped, then 0x22, 0x33, cmd 0x10 -> err=0x20, n_data=2.
//   5. Data 0x01, 0x02, then cmd 0x01 with parity flipped
//      -> err=0x40; hold cmd_ready=0 for 20 clks and send a frame
//         -> outputs unchanged; pulse cmd_ready -> n_data=0, err=0.
//   6. enable_n high after 4 bits, then data 0x07, 0x09, cmd 0x01 -> n_data=2, err=0.
//      Then rst_n low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: command/status encodings, frame width and parity helper.
package alu_pkg;

  localparam int unsigned WORD_W = 10;
  localparam int unsigned DATA_W = 8;

  typedef logic [DATA_W-1:0] command_t;

  // Status flags are one-hot so several can be OR-ed into one error byte.
  typedef enum logic [7:0] {
    S_OK                   = 8'h00,
    S_MISSING_DATA         = 8'h01,
    S_DATA_STACK_OVERFLOW  = 8'h02,
    S_INVALID_COMMAND      = 8'h04,
    S_DATA_PARITY_ERROR    = 8'h20,
    S_COMMAND_PARITY_ERROR = 8'h40
  } status_t;

  // Even parity over ctl + payload.
  function automatic logic calc_parity(input bit [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/alu_rx_shifter.sv
// Serial deserialiser: counts frame bits, shifts din MSB first, flags the completed word
// and its parity in the same cycle as the 10th sample.
module alu_rx_shifter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_n,
  input  logic              din,
  output logic              word_stb_c,
  output logic [WORD_W-1:0] word_c,
  output logic              par_ok_c
);

  localparam int unsigned CNT_W = $clog2(WORD_W);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-2:0] sh_q, sh_d;
  logic              last_bit;

  assign last_bit   = (cnt_q == CNT_W'(WORD_W - 1));
  assign word_stb_c = !enable_n && last_bit;
  assign word_c     = {sh_q, din};
  assign par_ok_c   = (word_c[0] == calc_parity(word_c[WORD_W-1:1]));

  // enable_n high at any point drops the partial word.
  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (enable_n) begin
      cnt_d = '0;
    end else if (last_bit) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      sh_d  = {sh_q[WORD_W-3:0], din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/alu_serial_rx.sv
// ALU serial front end: operand stack, sticky error flags and the command valid/ready
// register presented to the execute stage.
module alu_serial_rx
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_n,
  input  logic             din,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [7:0]       cmd,
  output logic [7:0]       err,
  output logic [IDX_W-1:0] n_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  localparam int unsigned SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              word_stb_c;
  logic [WORD_W-1:0] word_c;
  logic              par_ok_c;

  alu_rx_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_n   (enable_n),
    .din        (din),
    .word_stb_c (word_stb_c),
    .word_c     (word_c),
    .par_ok_c   (par_ok_c)
  );

  logic [7:0]       stack_q [DEPTH];
  command_t         cmd_q, cmd_d;
  logic [7:0]       err_q, err_d;
  logic [IDX_W-1:0] n_data_q, n_data_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             push_c;
  logic             ctl;
  logic [7:0]       payload;
  logic             full;

  assign ctl     = word_c[WORD_W-1];
  assign payload = word_c[WORD_W-2:1];
  assign full    = (n_data_q == IDX_W'(DEPTH));

  // Frames are ignored while a command is pending, including one landing on the handshake edge.
  always_comb begin
    cmd_d       = cmd_q;
    err_d       = err_q;
    n_data_d    = n_data_q;
    cmd_valid_d = cmd_valid_q;
    push_c      = 1'b0;
    if (cmd_valid_q) begin
      if (cmd_ready) begin
        cmd_valid_d = 1'b0;
        n_data_d    = '0;
        err_d       = '0;
      end
    end else if (word_stb_c) begin
      if (ctl) begin
        cmd_d       = payload;
        cmd_valid_d = 1'b1;
        if (!par_ok_c)
          err_d = err_d | 8'(S_COMMAND_PARITY_ERROR);
        if (n_data_q < IDX_W'(2))
          err_d = err_d | 8'(S_MISSING_DATA);
      end else if (!par_ok_c) begin
        err_d = err_d | 8'(S_DATA_PARITY_ERROR);
      end else if (full) begin
        err_d = err_d | 8'(S_DATA_STACK_OVERFLOW);
      end else begin
        push_c   = 1'b1;
        n_data_d = n_data_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      err_q       <= '0;
      n_data_q    <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      err_q       <= err_d;
      n_data_q    <= n_data_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stack_q[i] <= '0;
    end else if (push_c) begin
      stack_q[n_data_q[SEL_W-1:0]] <= payload;
    end
  end

  // Reads past the filled region return zero.
  always_comb begin
    rd_data = '0;
    if (rd_idx < n_data_q)
      rd_data = stack_q[rd_idx[SEL_W-1:0]];
  end

  assign cmd       = cmd_q;
  assign err       = err_q;
  assign n_data    = n_data_q;
  assign cmd_valid = cmd_valid_q;

endmodule
